serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub.sv | 157 +++++++++++++++
 tb/tb_serial_sub.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
//
// Purpose:
//   This is a bit-serial subtractor. It computes d = a - b - bin modulo
//   2^WIDTH, and it processes one bit per clock, LSB first.
//   - An accepted start captures the operands and the borrow-in.
//   - WIDTH RUN cycles follow.
//   - A single DONE cycle then pulses done and presents the result.
//
// Configuration:
//   SERIAL_SUB_OVF_EN - when defined, adds the ovf output. ovf is the signed
//                       two's-complement overflow of the subtraction.
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request; accepted in IDLE or DONE
//   a      in   [WIDTH] minuend
//   b      in   [WIDTH] subtrahend
//   bin    in   borrow-in
//   busy   out  high while the operation is running
//   done   out  one-cycle pulse when d/bout(/ovf) become valid
//   d      out  [WIDTH] difference, held until the next result
//   bout   out  borrow-out (unsigned underflow)
//   ovf    out  signed overflow (SERIAL_SUB_OVF_EN only)
//
// States:
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | shifting one bit per cycle through the subtractor
//   S_DONE | result loaded, done pulsed; start here chains the next op
// -----------------------------------------------------------------------------
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_dsh;
    logic [WIDTH-1:0] r_d;
    logic             r_br;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_ovf;
`endif

    logic             w_ai;
    logic             w_bi;
    logic             w_diff;
    logic             w_br_next;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_dsh_next;

    assign w_ai      = r_a[0];
    assign w_bi      = r_b[0];
    assign w_diff    = w_ai ^ w_bi ^ r_br;
    assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_accept  = start && (r_state != S_RUN);

    // Each new difference bit enters at the MSB. After WIDTH shifts, bit 0
    // sits in bit 0. This form also stays legal when WIDTH == 1.
    assign w_dsh_next = (r_dsh >> 1) | (WIDTH'(w_diff) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_dsh  <= '0;
            r_d    <= '0;
            r_br   <= 1'b0;
            r_bout <= 1'b0;
            r_cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_dsh <= '0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_next;
            r_dsh <= w_dsh_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_d    <= w_dsh_next;
                r_bout <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
                // On the last bit, r_a[0] and r_b[0] hold the captured
                // operand MSBs, and w_diff is the result MSB.
                r_ovf  <= (w_ai ^ w_bi) & (w_ai ^ w_diff);
`endif
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign d    = r_d;
    assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, bin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bout8;
    logic [7:0] d8;
    logic       ovf8;

    logic       start1, a1, b1, bin1;
    logic       busy1, done1, d1, bout1;
    logic       ovf1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8),
`ifdef SERIAL_SUB_OVF_EN
        .bout(bout8), .ovf(ovf8)
`else
        .bout(bout8)
`endif
    );

    serial_sub #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .d(d1),
`ifdef SERIAL_SUB_OVF_EN
        .bout(bout1), .ovf(ovf1)
`else
        .bout(bout1)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf8 = 1'b0;
    assign ovf1 = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit arithmetic; ovf from operand and result MSBs.
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [8:0] full;
        logic       ov;
        full = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        ov   = (a[7] ^ b[7]) & (a[7] ^ full[7]);
        return {ov, full};
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, input string tag);
        int         n;
        bit         seen;
        logic [9:0] r;
        logic [7:0] prev_d;
        prev_d = d8;
        r = ref8(a, b, bi);
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 1;
        seen = 0;
        check({tag, "_busy"}, busy8, 1'b1);
        while (!seen && n < 30) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            @(posedge clk); #1;
            n++;
            if (done8) seen = 1;
            else if (busy8 && n == 5) check({tag, "_hold_d"}, d8, prev_d);
        end
        check({tag, "_seen"}, seen, 1'b1);
        check({tag, "_lat"}, n, 9);
        check({tag, "_d"}, d8, r[7:0]);
        check({tag, "_bout"}, bout8, r[8]);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, ovf8, r[9]);
`endif
        @(posedge clk); #1;
        check({tag, "_pulse"}, done8, 1'b0);
    endtask

    task automatic op1(input logic a, input logic b, input logic bi, input string tag);
        int         n;
        bit         seen;
        logic [1:0] full;
        full = {1'b0, a} - {1'b0, b} - {1'b0, bi};
        @(negedge clk);
        a1 = a; b1 = b; bin1 = bi; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        a1 = ~a; b1 = ~b; bin1 = ~bi;
        n = 1;
        seen = 0;
        while (!seen && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (done1) seen = 1;
        end
        check({tag, "_lat"}, n, 2);
        check({tag, "_d"}, d1, full[0]);
        check({tag, "_bout"}, bout1, full[1]);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, ovf1, (a ^ b) & (a ^ full[0]));
`endif
    endtask

    logic [7:0] opa[0:63];
    logic [7:0] opb[0:63];
    logic       opc[0:63];
    logic [9:0] rr;
    int         ndone;
    int         acc;
    logic       done_seen;

    initial begin
        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        #1;
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_d", d8, 8'h00);
        check("rst_bout", bout8, 1'b0);
        check("rst_ovf", ovf8, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        op8(8'h05, 8'h03, 1'b0, "basic");
        op8(8'h00, 8'h01, 1'b0, "under");
        op8(8'hFF, 8'hFF, 1'b1, "ffbin");
        for (int i = 0; i < 12; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", i));

        // Hold start high and change the operands every cycle.
        ndone = 0;
        for (int e = 0; e < 36; e++) begin
            @(negedge clk);
            opa[e] = 8'($urandom); opb[e] = 8'($urandom); opc[e] = 1'($urandom);
            a8 = opa[e]; b8 = opb[e]; bin8 = opc[e]; start8 = 1'b1;
            @(posedge clk); #1;
            if (done8) begin
                ndone++;
                acc = e - 8;
                check("b2b_phase", e % 9, 8);
                if (acc >= 0) begin
                    rr = ref8(opa[acc], opb[acc], opc[acc]);
                    check("b2b_d", d8, rr[7:0]);
                    check("b2b_bout", bout8, rr[8]);
                end
            end
        end
        check("b2b_count", ndone, 4);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(posedge clk);

        op8(8'h80, 8'h01, 1'b0, "ovf");

        // Pull reset in the middle of an operation.
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; bin8 = 0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_busy", busy8, 1'b0);
        check("mid_done", done8, 1'b0);
        check("mid_d", d8, 8'h00);
        check("mid_bout", bout8, 1'b0);
        check("mid_ovf", ovf8, 1'b0);
        done_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) done_seen = 1;
        end
        check("mid_nodone", done_seen, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        op8(8'h10, 8'h01, 1'b0, "after_rst");

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0], $sformatf("w1_%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
